dtack_generator: RTL and testbench

DTACK_GENERATOR -- requirements
Module: dtack_generator

---
 rtl/dtack_generator.sv | 177 +++++++++++++++++
 tb/tb_dtack_generator.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtack_generator.sv
// ---------------------------------------------------------------------------
// dtack_generator
//   Generates the 68k DTACK_L / BERR_L handshake for every bus cycle.
//   On-chip ROM, on-chip RAM and IO/graphics accesses are acknowledged after
//   a fixed number of wait states. DRAM and CAN accesses wait for the
//   controller's own acknowledge. A cycle that is never acknowledged ends in
//   a bus error after TIMEOUT clocks.
//
// Parameters
//   ROM_WAIT   wait states for on-chip ROM
//   RAM_WAIT   wait states for on-chip RAM
//   IO_WAIT    wait states for IO and graphics
//   TIMEOUT    clocks without acknowledge before BERR_L (1..255)
//
// Ports
//   Clock                 system clock, rising edge
//   Reset_L               asynchronous reset, active low
//   AS_L, UDS_L, LDS_L    68k address / data strobes, active low
//   OnChipRomSelect_H     decoder select, on-chip ROM
//   OnChipRamSelect_H     decoder select, on-chip RAM
//   IOSelect_H            decoder select, IO
//   DramSelect_H          decoder select, DRAM
//   CanBusSelect_H        decoder select, CAN controller
//   GraphicsCS_L          decoder select, graphics, active low
//   DramDtack_L           acknowledge from the DRAM controller
//   CanBusDtack_L         acknowledge from the CAN controller
//   DTACK_L               registered data transfer acknowledge to the CPU
//   BERR_L                registered bus error to the CPU
// ---------------------------------------------------------------------------
module dtack_generator #(
    parameter int unsigned ROM_WAIT = 1,
    parameter int unsigned RAM_WAIT = 0,
    parameter int unsigned IO_WAIT  = 2,
    parameter int unsigned TIMEOUT  = 200
) (
    input  logic Clock,
    input  logic Reset_L,
    input  logic AS_L,
    input  logic UDS_L,
    input  logic LDS_L,
    input  logic OnChipRomSelect_H,
    input  logic OnChipRamSelect_H,
    input  logic IOSelect_H,
    input  logic DramSelect_H,
    input  logic CanBusSelect_H,
    input  logic GraphicsCS_L,
    input  logic DramDtack_L,
    input  logic CanBusDtack_L,
    output logic DTACK_L,
    output logic BERR_L
);

    localparam logic [7:0] ROM_LOAD  = 8'(ROM_WAIT);
    localparam logic [7:0] RAM_LOAD  = 8'(RAM_WAIT);
    localparam logic [7:0] IO_LOAD   = 8'(IO_WAIT);
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        EXTWAIT,
        ACK,
        ERR
    } state_t;

    // External acknowledge source latched at cycle start.
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_CAN,
        SRC_DRAM
    } src_t;

    state_t     state, state_next;
    src_t       src, src_next;
    logic [7:0] wait_cnt, wait_next;
    logic [7:0] tmo_cnt, tmo_next;
    logic [7:0] tmo_inc;
    logic       cycle_start;
    logic       ext_ack;

    assign cycle_start = !AS_L && (!UDS_L || !LDS_L);
    assign tmo_inc     = tmo_cnt + 8'd1;

    // Only the acknowledge of the source chosen at cycle start counts.
    assign ext_ack = ((src == SRC_CAN)  && !CanBusDtack_L) ||
                     ((src == SRC_DRAM) && !DramDtack_L);

    always_comb begin
        state_next = state;
        src_next   = src;
        wait_next  = wait_cnt;
        tmo_next   = tmo_cnt;

        case (state)
            IDLE: begin
                if (cycle_start) begin
                    wait_next = '0;
                    tmo_next  = '0;
                    src_next  = SRC_NONE;
                    if (OnChipRomSelect_H) begin
                        wait_next  = ROM_LOAD;
                        state_next = COUNT;
                    end else if (OnChipRamSelect_H) begin
                        wait_next  = RAM_LOAD;
                        state_next = COUNT;
                    end else if (IOSelect_H || !GraphicsCS_L) begin
                        wait_next  = IO_LOAD;
                        state_next = COUNT;
                    end else if (CanBusSelect_H) begin
                        src_next   = SRC_CAN;
                        state_next = EXTWAIT;
                    end else if (DramSelect_H) begin
                        src_next   = SRC_DRAM;
                        state_next = EXTWAIT;
                    end else begin
                        // Unmapped: nothing will acknowledge, only the timeout ends it.
                        state_next = EXTWAIT;
                    end
                end
            end

            COUNT: begin
                if (AS_L) begin
                    state_next = IDLE;
                end else if (wait_cnt == '0) begin
                    state_next = ACK;
                end else begin
                    wait_next = wait_cnt - 8'd1;
                end
            end

            EXTWAIT: begin
                // Abort beats acknowledge; acknowledge beats timeout.
                if (AS_L) begin
                    state_next = IDLE;
                end else if (ext_ack) begin
                    state_next = ACK;
                end else if (tmo_inc == TMO_LIMIT) begin
                    state_next = ERR;
                end else begin
                    tmo_next = tmo_inc;
                end
            end

            ACK, ERR: begin
                if (AS_L) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            state    <= IDLE;
            src      <= SRC_NONE;
            wait_cnt <= '0;
            tmo_cnt  <= '0;
            DTACK_L  <= 1'b1;
            BERR_L   <= 1'b1;
        end else begin
            state    <= state_next;
            src      <= src_next;
            wait_cnt <= wait_next;
            tmo_cnt  <= tmo_next;
            // Outputs are registered from the next state so they change on
            // the same edge as the state that owns them.
            DTACK_L  <= (state_next != ACK);
            BERR_L   <= (state_next != ERR);
        end
    end

endmodule

// File: tb/tb_dtack_generator.sv
// ---------------------------------------------------------------------------
// tb_dtack_generator
//   Self-checking bench for dtack_generator: a table of hand-derived vectors,
//   directed multi-cycle sequences (external acknowledge, timeout, abort,
//   asynchronous reset) and a randomized phase compared against a
//   transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_dtack_generator;

    localparam int unsigned P_ROM = 1;
    localparam int unsigned P_RAM = 0;
    localparam int unsigned P_IO  = 2;
    localparam int unsigned P_TMO = 200;

    logic Clock = 1'b0;
    logic Reset_L;
    logic AS_L, UDS_L, LDS_L;
    logic OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H;
    logic DramSelect_H, CanBusSelect_H, GraphicsCS_L;
    logic DramDtack_L, CanBusDtack_L;
    logic DTACK_L, BERR_L;

    int checks = 0;
    int errors = 0;

    dtack_generator #(
        .ROM_WAIT(P_ROM),
        .RAM_WAIT(P_RAM),
        .IO_WAIT (P_IO),
        .TIMEOUT (P_TMO)
    ) dut (
        .Clock            (Clock),
        .Reset_L          (Reset_L),
        .AS_L             (AS_L),
        .UDS_L            (UDS_L),
        .LDS_L            (LDS_L),
        .OnChipRomSelect_H(OnChipRomSelect_H),
        .OnChipRamSelect_H(OnChipRamSelect_H),
        .IOSelect_H       (IOSelect_H),
        .DramSelect_H     (DramSelect_H),
        .CanBusSelect_H   (CanBusSelect_H),
        .GraphicsCS_L     (GraphicsCS_L),
        .DramDtack_L      (DramDtack_L),
        .CanBusDtack_L    (CanBusDtack_L),
        .DTACK_L          (DTACK_L),
        .BERR_L           (BERR_L)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic as_l, uds_l, lds_l;
        logic rom, ram, io, gcs_l, can, dram;
        logic can_dt_l, dram_dt_l;
    } bus_t;

    typedef struct {
        bus_t in;
        logic exp_dtack_l;
        logic exp_berr_l;
    } vec_t;

    vec_t vecs[$];

    function automatic bus_t mk(input logic as_l, input logic uds_l, input logic lds_l,
                                input logic rom, input logic ram, input logic io,
                                input logic gcs_l, input logic can, input logic dram,
                                input logic can_dt_l, input logic dram_dt_l);
        bus_t b;
        b.as_l = as_l; b.uds_l = uds_l; b.lds_l = lds_l;
        b.rom = rom; b.ram = ram; b.io = io; b.gcs_l = gcs_l;
        b.can = can; b.dram = dram;
        b.can_dt_l = can_dt_l; b.dram_dt_l = dram_dt_l;
        return b;
    endfunction

    task automatic addv(input bus_t b, input logic d, input logic e);
        vec_t v;
        v.in = b; v.exp_dtack_l = d; v.exp_berr_l = e;
        vecs.push_back(v);
    endtask

    task automatic apply(input bus_t b);
        AS_L = b.as_l; UDS_L = b.uds_l; LDS_L = b.lds_l;
        OnChipRomSelect_H = b.rom; OnChipRamSelect_H = b.ram;
        IOSelect_H = b.io; GraphicsCS_L = b.gcs_l;
        CanBusSelect_H = b.can; DramSelect_H = b.dram;
        CanBusDtack_L = b.can_dt_l; DramDtack_L = b.dram_dt_l;
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic cyc(input bus_t b);
        apply(b);
        step();
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // DTACK_L and BERR_L must never be low together.
    always @(negedge Clock) begin
        checks++;
        if (DTACK_L === 1'b0 && BERR_L === 1'b0) begin
            errors++;
            $display("FAIL exclusive: DTACK_L=%b BERR_L=%b, required not both 0 (t=%0t)",
                     DTACK_L, BERR_L, $time);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- transaction-level reference model ----------------
    // A cycle is described by its start, its kind and the clocks elapsed
    // since start; the expected acknowledge follows from simple arithmetic.
    localparam int K_FIXED = 0, K_CAN = 1, K_DRAM = 2, K_NONE = 3;
    bit m_busy, m_dtack, m_berr;
    int m_elapsed, m_kind, m_lat;

    task automatic model_reset();
        m_busy = 0; m_dtack = 0; m_berr = 0; m_elapsed = 0; m_kind = K_NONE; m_lat = 0;
    endtask

    task automatic model_edge(input bus_t b);
        bit ack;
        if (!m_busy) begin
            m_dtack = 0; m_berr = 0;
            if (!b.as_l && (!b.uds_l || !b.lds_l)) begin
                m_busy = 1; m_elapsed = 0;
                if (b.rom)                    begin m_kind = K_FIXED; m_lat = P_ROM; end
                else if (b.ram)               begin m_kind = K_FIXED; m_lat = P_RAM; end
                else if (b.io || !b.gcs_l)    begin m_kind = K_FIXED; m_lat = P_IO;  end
                else if (b.can)               m_kind = K_CAN;
                else if (b.dram)              m_kind = K_DRAM;
                else                          m_kind = K_NONE;
            end
        end else if (m_dtack || m_berr) begin
            if (b.as_l) begin m_busy = 0; m_dtack = 0; m_berr = 0; end
        end else begin
            m_elapsed++;
            if (b.as_l) begin
                m_busy = 0;
            end else if (m_kind == K_FIXED) begin
                if (m_elapsed == m_lat + 1) m_dtack = 1;
            end else begin
                ack = (m_kind == K_CAN && !b.can_dt_l) || (m_kind == K_DRAM && !b.dram_dt_l);
                if (ack) m_dtack = 1;
                else if (m_elapsed == int'(P_TMO)) m_berr = 1;
            end
        end
    endtask

    function automatic bus_t rand_bus(input bit as_active, input bit unmapped);
        bus_t b;
        b.as_l = !as_active;
        if ($urandom_range(0, 7) == 0) begin
            b.uds_l = 1'b1; b.lds_l = 1'b1;
        end else begin
            b.uds_l = 1'($urandom_range(0, 1));
            b.lds_l = b.uds_l ? 1'b0 : 1'($urandom_range(0, 1));
        end
        if (unmapped) begin
            b.rom = 0; b.ram = 0; b.io = 0; b.gcs_l = 1; b.can = 0; b.dram = 0;
        end else begin
            b.rom   = ($urandom_range(0, 4) == 0);
            b.ram   = ($urandom_range(0, 4) == 0);
            b.io    = ($urandom_range(0, 4) == 0);
            b.gcs_l = ($urandom_range(0, 4) != 0);
            b.can   = ($urandom_range(0, 3) == 0);
            b.dram  = ($urandom_range(0, 3) == 0);
        end
        b.can_dt_l  = ($urandom_range(0, 3) != 0);
        b.dram_dt_l = ($urandom_range(0, 3) != 0);
        return b;
    endfunction

    task automatic rcyc(input bus_t b);
        apply(b);
        @(posedge Clock);
        model_edge(b);
        #1;
        check("rand_dtack", DTACK_L, !m_dtack);
        check("rand_berr", BERR_L, !m_berr);
    endtask

    // ---------------- test ----------------
    initial begin
        bus_t idle_b, rom_b, ram_b, io_b, gfx_b, romdram_b, nostrobe_b;
        bus_t b;

        idle_b     = mk(1,1,1, 0,0,0,1, 0,0, 1,1);
        rom_b      = mk(0,0,1, 1,0,0,1, 0,0, 1,1);
        ram_b      = mk(0,1,0, 0,1,0,1, 0,0, 1,1);
        io_b       = mk(0,0,1, 0,0,1,1, 0,0, 1,1);
        gfx_b      = mk(0,0,0, 0,0,0,0, 0,0, 1,1);
        romdram_b  = mk(0,0,1, 1,0,0,1, 0,1, 1,0);
        nostrobe_b = mk(0,1,1, 1,0,0,1, 0,0, 1,1);

        // Reset state
        Reset_L = 1'b0;
        apply(idle_b);
        step();
        check("reset_dtack", DTACK_L, 1'b1);
        check("reset_berr", BERR_L, 1'b1);
        step();
        Reset_L = 1'b1;

        // ROM read, 1 wait state: low at start+2, high one clock after AS_L=1
        addv(rom_b, 1, 1); addv(rom_b, 1, 1); addv(rom_b, 0, 1); addv(rom_b, 0, 1);
        addv(idle_b, 1, 1); addv(idle_b, 1, 1);
        // RAM (0 waits) then IO (2 waits) back to back
        addv(ram_b, 1, 1); addv(ram_b, 0, 1); addv(idle_b, 1, 1);
        addv(io_b, 1, 1); addv(io_b, 1, 1); addv(io_b, 1, 1); addv(io_b, 0, 1);
        addv(idle_b, 1, 1);
        // Graphics select uses IO timing
        addv(gfx_b, 1, 1); addv(gfx_b, 1, 1); addv(gfx_b, 1, 1); addv(gfx_b, 0, 1);
        addv(idle_b, 1, 1);
        // ROM beats DRAM; DRAM acknowledge ignored
        addv(romdram_b, 1, 1); addv(romdram_b, 1, 1); addv(romdram_b, 0, 1);
        addv(idle_b, 1, 1);
        // Abort during COUNT: no acknowledge afterwards
        addv(io_b, 1, 1); addv(idle_b, 1, 1); addv(idle_b, 1, 1); addv(idle_b, 1, 1);
        // AS_L low without a data strobe never starts a cycle
        addv(nostrobe_b, 1, 1); addv(nostrobe_b, 1, 1); addv(nostrobe_b, 1, 1);
        addv(nostrobe_b, 1, 1); addv(idle_b, 1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].in);
            check($sformatf("vec%0d_dtack", i), DTACK_L, vecs[i].exp_dtack_l);
            check($sformatf("vec%0d_berr", i), BERR_L, vecs[i].exp_berr_l);
        end

        // DRAM: selects change after start (ignored), CAN ack ignored,
        // DRAM ack sampled on the 5th clock after start
        cyc(mk(0,0,1, 0,0,0,1, 0,1, 0,1));
        check("dram_start", DTACK_L, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            cyc(mk(0,0,1, 1,0,0,1, 0,0, 0,1));
            check("dram_wait", DTACK_L, 1'b1);
        end
        cyc(mk(0,0,1, 1,0,0,1, 0,0, 0,0));
        check("dram_ack", DTACK_L, 1'b0);
        cyc(idle_b);
        check("dram_release", DTACK_L, 1'b1);

        // CAN: DRAM ack ignored, CAN ack on 3rd clock
        cyc(mk(0,0,1, 0,0,0,1, 1,0, 1,0));
        cyc(mk(0,0,1, 0,0,0,1, 1,0, 1,0));
        check("can_wait1", DTACK_L, 1'b1);
        cyc(mk(0,0,1, 0,0,0,1, 1,0, 1,0));
        check("can_wait2", DTACK_L, 1'b1);
        cyc(mk(0,0,1, 0,0,0,1, 1,0, 0,0));
        check("can_ack", DTACK_L, 1'b0);
        cyc(idle_b);
        check("can_release", DTACK_L, 1'b1);

        // Unmapped: bus error exactly TIMEOUT clocks after start
        b = mk(0,0,0, 0,0,0,1, 0,0, 0,0);
        cyc(b);
        for (int k = 1; k < int'(P_TMO); k++) begin
            cyc(b);
            check("tmo_wait_berr", BERR_L, 1'b1);
        end
        cyc(b);
        check("tmo_berr", BERR_L, 1'b0);
        check("tmo_dtack", DTACK_L, 1'b1);
        cyc(b);
        check("tmo_berr_hold", BERR_L, 1'b0);
        cyc(idle_b);
        check("tmo_berr_release", BERR_L, 1'b1);

        // Acknowledge on the timeout edge wins
        cyc(mk(0,0,1, 0,0,0,1, 0,1, 1,1));
        for (int k = 1; k < int'(P_TMO); k++) cyc(mk(0,0,1, 0,0,0,1, 0,1, 1,1));
        check("race_pre", DTACK_L, 1'b1);
        cyc(mk(0,0,1, 0,0,0,1, 0,1, 1,0));
        check("race_dtack", DTACK_L, 1'b0);
        check("race_berr", BERR_L, 1'b1);
        cyc(idle_b);
        check("race_release", DTACK_L, 1'b1);

        // Abort during EXTWAIT, late DRAM ack does nothing
        cyc(mk(0,0,1, 0,0,0,1, 0,1, 1,1));
        cyc(idle_b);
        check("abort_ext", DTACK_L, 1'b1);
        cyc(mk(1,1,1, 0,0,0,1, 0,1, 1,0));
        check("abort_late_dtack", DTACK_L, 1'b1);
        check("abort_late_berr", BERR_L, 1'b1);

        // Reset while in ACK releases DTACK_L without a clock edge
        cyc(ram_b);
        cyc(ram_b);
        check("pre_reset_ack", DTACK_L, 1'b0);
        #2;
        Reset_L = 1'b0;
        #1;
        check("reset_async_dtack", DTACK_L, 1'b1);
        step();
        check("reset_hold_dtack", DTACK_L, 1'b1);
        Reset_L = 1'b1;
        step();
        check("post_reset_start", DTACK_L, 1'b1);
        step();
        check("post_reset_ack", DTACK_L, 1'b0);
        cyc(idle_b);
        check("post_reset_release", DTACK_L, 1'b1);

        // Randomized phase against the reference model
        Reset_L = 1'b0;
        apply(idle_b);
        step();
        Reset_L = 1'b1;
        model_reset();
        for (int t = 0; t < 250; t++) begin
            bit unmapped;
            int hold;
            int gap;
            unmapped = ($urandom_range(0, 24) == 0);
            hold = unmapped ? 205 : int'($urandom_range(1, 12));
            gap = int'($urandom_range(1, 3));
            for (int c = 0; c < hold + gap; c++) begin
                rcyc(rand_bus(c < hold, unmapped));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
